// File: rtl/pat_mon_if.sv
// pat_mon_if: beat input and monitor status bundle for pat_mon
interface pat_mon_if #(
  parameter int ERR_W = 8,
  parameter int FRM_W = 8
);
  logic             en_in;
  logic [2:0]       d_in;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
  logic [FRM_W-1:0] frm_cnt;
  logic [1:0]       state;
  modport master (output en_in, d_in, input locked, err, err_cnt, frm_cnt, state);
  modport slave  (input en_in, d_in, output locked, err, err_cnt, frm_cnt, state);
endinterface

// File: rtl/pat_mon.sv
// pat_mon: checks a 4-beat 001,011,100,010 pattern stream, counting errors and good frames
// Optional frame counter enabled by defining PAT_MON_FRAME_CNT_EN (otherwise frm_cnt is tied to zero).
module pat_mon #(
  parameter int ERR_W = 8,
  parameter int FRM_W = 8
) (
  input logic      clk,
  input logic      rst,
  pat_mon_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, ACQ = 2'b01, LOCK = 2'b10} state_t;
  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [2:0]       exp_d;
  logic             match, frame_done;
  always_comb begin
    exp_d = idx_q == 2'd0 ? 3'b001 : idx_q == 2'd1 ? 3'b011 : idx_q == 2'd2 ? 3'b100 : 3'b010;
    match = bus.d_in == exp_d;
    frame_done = bus.en_in && match && idx_q == 2'd3;
    err_d = bus.en_in ? !match : bus.d_in != 3'b000;
    err_cnt_d = err_d && !(&err_cnt_q) ? err_cnt_q + 1'b1 : err_cnt_q;
    state_d = !bus.en_in ? IDLE : !match ? ACQ : frame_done ? LOCK : state_q == IDLE ? ACQ : state_q;
    // a stray 001 is the start of a frame, so resync straight to index 1
    idx_d = !bus.en_in ? 2'd0 : match ? idx_q + 2'd1 : {1'b0, bus.d_in == 3'b001};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign bus.state   = state_q;
  assign bus.locked  = state_q == LOCK;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;
`ifdef PAT_MON_FRAME_CNT_EN
  logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
  always_comb frm_cnt_d = frame_done && !(&frm_cnt_q) ? frm_cnt_q + 1'b1 : frm_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) frm_cnt_q <= '0;
    else frm_cnt_q <= frm_cnt_d;
  end
  assign bus.frm_cnt = frm_cnt_q;
`else
  assign bus.frm_cnt = {FRM_W{1'b0}};
`endif
endmodule

// File: tb/tb_pat_mon.sv
// tb_pat_mon: directed pattern-monitor bench with an in-bench reference model and per-cycle compare
module tb_pat_mon;
`ifdef PAT_MON_FRAME_CNT_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  logic       clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [2:0] d = 3'b000;
  int checks = 0, errors = 0;
  bit started = 1'b0;
  pat_mon_if #(.ERR_W(8), .FRM_W(8)) b0 ();
  pat_mon_if #(.ERR_W(2), .FRM_W(2)) b1 ();
  assign b0.en_in = en;
  assign b0.d_in  = d;
  assign b1.en_in = en;
  assign b1.d_in  = d;
  pat_mon #(.ERR_W(8), .FRM_W(8)) d0 (.clk(clk), .rst(rst), .bus(b0));
  pat_mon #(.ERR_W(2), .FRM_W(2)) d1 (.clk(clk), .rst(rst), .bus(b1));
  always #5 clk = ~clk;
  // reference: frame position, mode (0 idle,1 hunting,2 locked), unbounded event tallies
  logic [2:0] pat [4] = '{3'b001, 3'b011, 3'b100, 3'b010};
  int m_st = 0, m_pos = 0, m_ec = 0, m_fc = 0;
  bit m_err = 1'b0;
  always @(posedge clk) begin
    started = 1'b1;
    m_err = 1'b0;
    if (rst) begin
      m_st = 0; m_pos = 0; m_ec = 0; m_fc = 0;
    end else if (!en) begin
      m_err = d != 3'b000;
      m_st = 0; m_pos = 0;
    end else if (d == pat[m_pos]) begin
      if (m_pos == 3) begin m_fc++; m_st = 2; end
      else if (m_st == 0) m_st = 1;
      m_pos = (m_pos + 1) % 4;
    end else begin
      m_err = 1'b1;
      m_st = 1;
      m_pos = d == 3'b001 ? 1 : 0;
    end
    if (m_err) m_ec++;
  end
  function automatic int sat(int v, int w);
    return v > (1 << w) - 1 ? (1 << w) - 1 : v;
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) if (started) begin
    chk("state",    32'(b0.state),   m_st);
    chk("locked",   32'(b0.locked),  32'(m_st == 2));
    chk("err",      32'(b0.err),     32'(m_err));
    chk("err_cnt",  32'(b0.err_cnt), sat(m_ec, 8));
    chk("frm_cnt",  32'(b0.frm_cnt), FE ? sat(m_fc, 8) : 0);
    chk("s_state",  32'(b1.state),   m_st);
    chk("s_err",    32'(b1.err),     32'(m_err));
    chk("s_errcnt", 32'(b1.err_cnt), sat(m_ec, 2));
    chk("s_frmcnt", 32'(b1.frm_cnt), FE ? sat(m_fc, 2) : 0);
  end
  task automatic beat(input logic r, input logic e, input logic [2:0] v);
    @(negedge clk);
    rst = r; en = e; d = v;
  endtask
  task automatic frame();
    beat(0, 1, 3'b001); beat(0, 1, 3'b011); beat(0, 1, 3'b100); beat(0, 1, 3'b010);
  endtask
  task automatic settle();
    @(posedge clk);
    #1;
  endtask
  task automatic lit(string n, logic [1:0] st, logic er, int ec, int fc);
    chk({n, "_state"},  32'(b0.state),   32'(st));
    chk({n, "_locked"}, 32'(b0.locked),  32'(st == 2'b10));
    chk({n, "_err"},    32'(b0.err),     32'(er));
    chk({n, "_errcnt"}, 32'(b0.err_cnt), ec);
    chk({n, "_frmcnt"}, 32'(b0.frm_cnt), FE ? fc : 0);
  endtask
  initial begin
    beat(1, 0, 3'b000); beat(1, 0, 3'b000); settle();
    lit("reset", 2'b00, 0, 0, 0);
    chk("model_reset", 32'(m_ec + m_fc + m_st), 0);
    beat(0, 1, 3'b001); beat(0, 1, 3'b011); beat(0, 1, 3'b100); settle();
    lit("acq3", 2'b01, 0, 0, 0);
    beat(0, 1, 3'b010); settle();
    lit("lock4", 2'b10, 0, 0, 1);
    frame(); settle();
    lit("lock8", 2'b10, 0, 0, 2);
    chk("model_frm8", 32'(m_fc), 2);
    beat(0, 1, 3'b001); beat(0, 1, 3'b011); beat(0, 1, 3'b011); settle();
    lit("inject", 2'b01, 1, 1, 2);
    chk("model_inject_ec", 32'(m_ec), 1);
    frame(); settle();
    lit("relock", 2'b10, 0, 1, 3);
    beat(0, 1, 3'b001); beat(0, 1, 3'b011); beat(0, 0, 3'b000); beat(0, 0, 3'b000); settle();
    lit("drop", 2'b00, 0, 1, 3);
    frame(); settle();
    lit("restart", 2'b10, 0, 1, 4);
    beat(0, 0, 3'b101); settle();
    lit("idle1", 2'b00, 1, 2, 4);
    beat(0, 0, 3'b101); beat(0, 0, 3'b101); settle();
    lit("idle3", 2'b00, 1, 4, 4);
    chk("sat_errcnt", 32'(b1.err_cnt), 3);
    beat(0, 0, 3'b000); settle();
    lit("idle_ok", 2'b00, 0, 4, 4);
    beat(0, 1, 3'b001); beat(0, 1, 3'b001); settle();
    lit("resync", 2'b01, 1, 5, 4);
    beat(0, 1, 3'b011); beat(0, 1, 3'b100); beat(0, 1, 3'b010); settle();
    lit("resync_lock", 2'b10, 0, 5, 5);
    chk("sat_frmcnt", 32'(b1.frm_cnt), FE ? 3 : 0);
    beat(0, 1, 3'b001); beat(0, 0, 3'b011); settle();
    lit("drop_mismatch", 2'b00, 1, 6, 5);
    frame(); beat(0, 1, 3'b001); beat(0, 1, 3'b011); settle();
    lit("prerst", 2'b10, 0, 6, 6);
    beat(1, 1, 3'b100); settle();
    lit("rst_lock", 2'b00, 0, 0, 0);
    chk("rst_small_errcnt", 32'(b1.err_cnt), 0);
    beat(0, 1, 3'b011); settle();
    lit("post_rst", 2'b01, 1, 1, 0);
    beat(0, 0, 3'b000); beat(0, 0, 3'b000); settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pat_mon.md
PAT_MON -- requirements
Module: pat_mon

Interface
REQ-001 The parameter ERR_W, default 8, SHALL set the width of the saturating error counter err_cnt.
REQ-002 The parameter FRM_W, default 8, SHALL set the width of the saturating frame counter frm_cnt.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 en_in  input  1  SHALL be the beat-valid qualifier, aligned to the same cycle as d_in, i.e. the generator enable delayed one register stage.
REQ-006 d_in  input  3  SHALL be the pattern-generator output under check.
REQ-007 locked  output  1  SHALL be high while the monitor is in LOCK.
REQ-008 err  output  1  SHALL be a one-cycle pulse, one cycle after a failing sample.
REQ-009 err_cnt  output  ERR_W  SHALL hold the total errors, saturating at all-ones.
REQ-010 frm_cnt  output  FRM_W  SHALL hold the completed good frames, saturating at all-ones.
REQ-011 state  output  2  SHALL expose the FSM encoding: IDLE=00, ACQ=01, LOCK=10.

Function
REQ-012 The expected frame SHALL be 001, 011, 100, 010 (index 0..3); the index SHALL wrap from 3 to 0.
REQ-013 With en_in=0, the FSM SHALL go to IDLE, index SHALL be 0, locked SHALL be 0, and a partial frame SHALL be discarded without counting.
REQ-014 With en_in=0, d_in SHALL be required to equal 000; any other value SHALL produce an err pulse and increment err_cnt.
REQ-015 The first en_in=1 sample after IDLE SHALL be compared against index 0, and the FSM SHALL enter ACQ.
REQ-016 In ACQ, a match SHALL advance the index; four consecutive matches ending at index 3 SHALL move the FSM to LOCK on the next edge.
REQ-017 In ACQ, a mismatch SHALL pulse err and increment err_cnt; if d_in=001 the index SHALL resync to 1, otherwise the index SHALL become 0.
REQ-018 In LOCK, a match SHALL advance the index; each match at index 3 SHALL increment frm_cnt.
REQ-019 In LOCK, a mismatch SHALL pulse err, increment err_cnt, clear locked, and move the FSM to ACQ using the resync rule of REQ-017.
REQ-020 The frame that produces the ACQ-to-LOCK transition SHALL also increment frm_cnt.
REQ-021 Both counters SHALL saturate and never wrap.
REQ-022 The err pulse SHALL never last more than one cycle per failing sample; back-to-back failures SHALL give a continuous high.
REQ-023 An en_in deassertion on the same edge as a mismatch SHALL be treated as an idle-cycle check (REQ-014), not a frame mismatch.

Reset
REQ-024 While rst=1 at a rising edge: state SHALL be IDLE, index 0, locked 0, err 0, err_cnt 0, frm_cnt 0.
REQ-025 rst SHALL take priority over en_in and d_in, including when asserted mid-frame or in LOCK.
REQ-026 The first sample after rst is released SHALL be evaluated normally.

Configuration
REQ-027 With PAT_MON_FRAME_CNT_EN defined, frm_cnt SHALL count per REQ-018 and REQ-020.
REQ-028 Without PAT_MON_FRAME_CNT_EN, frm_cnt SHALL be constant zero and no frame-counter register SHALL be synthesised; all other behaviour SHALL be unchanged.

Verification
REQ-029 Reset, then en_in=1 for 8 cycles of the correct sequence -> locked rises after the 4th beat, frm_cnt=2, err_cnt=0, err never high.
REQ-030 Locked stream, then 011 injected at index 2 -> one err pulse, err_cnt=1, locked=0, state=ACQ; the following 4 good beats relock.
REQ-031 en_in dropped after 2 beats, d_in=000 for 2 cycles, then restarted -> no err, frm_cnt unchanged, checking restarts at index 0.
REQ-032 en_in=0 with d_in=101 for 3 cycles -> err high 3 consecutive cycles, err_cnt=3.
REQ-033 ERR_W=2 with 5 forced errors -> err_cnt holds 3; rst asserted in LOCK -> all outputs zero on the next edge.
REQ-034 Build without PAT_MON_FRAME_CNT_EN, repeat REQ-029 -> frm_cnt=0, locked and err behaviour identical.
